pipelined_barrel_shifter: RTL
=============================

# pipelined_barrel_shifter

Parametrised, pipelined barrel shifter. It supersedes the single-cycle combinational shifter in the datapath and adds arithmetic-right and rotate modes, a valid/ready handshake on both sides, and one register stage per shift bit. Throughput is one operation per clock. It sits between the operand-select logic and the result writeback path, and backpressure from writeback stalls the whole pipe.

## Interface
Parameters:
- IWIDTH, default 8: data width. Must be a power of two, at least 2.
- SWIDTH, default 3: shift-amount width. Must equal log2(IWIDTH). Elaboration fails otherwise.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  upstream presents an operation.
- IN_READY  out  1  block can accept; combinational, equal to !OUT_VALID || OUT_READY.
- BS_DIR  in  1  shift direction: 1 = right, 0 = left.
- BS_MODE  in  2  operation: 00 logical, 01 arithmetic, 10 rotate, 11 reserved (executes as logical).
- BS_AMT  in  SWIDTH  shift amount, 0..IWIDTH-1.
- D_IN  in  IWIDTH  operand.
- OUT_VALID  out  1  D_OUT holds a completed result.
- OUT_READY  in  1  downstream accepts D_OUT.
- D_OUT  out  IWIDTH  result, registered.

## Operation
- Transfer in occurs on a rising edge with IN_VALID && IN_READY. Transfer out occurs on a rising edge with OUT_VALID && OUT_READY.
- Pipe enable EN = !OUT_VALID || OUT_READY, which is the same signal as IN_READY.
  - EN=1: every stage advances. Stage 0 loads D_IN, BS_AMT, BS_DIR, BS_MODE and valid = IN_VALID.
  - EN=0: every stage holds. No data or valid bit changes.
- Stage k (k = 0..SWIDTH-1) shifts its data by 2^k when amount bit k is 1, otherwise passes it through. It forwards dir, mode, remaining amount bits and valid to the next stage.
- The last stage's registers drive D_OUT and OUT_VALID directly.
- Fill rules:
  - Logical: zero fill in both directions.
  - Arithmetic right: fill with bit IWIDTH-1 of the original operand. That sign bit is captured at stage 0 and carried down the pipe.
  - Arithmetic left: identical to logical left.
  - Rotate: bits shifted out re-enter at the opposite end; no bits are lost.
- BS_AMT = 0 returns D_IN unchanged in every mode and direction.
- Bubbles (valid=0) advance like data. Their data contents are don't-care, but they must not raise OUT_VALID.
- No internal state exists beyond the stage registers. There is no FSM beyond valid tracking.

## Timing
- Reset (RST=1, asynchronous): all stage valid bits = 0, all stage data/amount/control registers = 0, OUT_VALID = 0, D_OUT = 0.
  - IN_READY = 1 while in reset and immediately after.
  - Reset asserted mid-operation discards every in-flight operation. Nothing is output for them.
- Latency: an operation accepted at edge N presents OUT_VALID=1 with its result after edge N+SWIDTH-1. With the default SWIDTH=3, that is 3 stage registers: the result is visible after edge N+2 and usable on edge N+3. Each stall cycle adds one cycle.
- Throughput: one accept per cycle while OUT_READY=1.
- Backpressure:
  - With OUT_VALID=1 and OUT_READY=0, IN_READY drops in the same cycle. D_OUT and OUT_VALID are held stable until the handshake.
  - Input fields are sampled only on an accepting edge.
- Simultaneous output and input transfers in one cycle are legal and lose no data.
- Ordering is strictly FIFO: results leave in acceptance order.
- An upstream that deasserts IN_VALID without a transfer has no effect.

## Test plan
Default parameters (IWIDTH=8, SWIDTH=3), OUT_READY=1 unless stated.
- Reset mid-stream: assert RST with 3 operations in flight -> OUT_VALID=0 and D_OUT=8'h00 immediately. After release, no stale result appears and IN_READY=1.
- Single operation with latency check: D_IN=8'hB4, BS_DIR=0, BS_MODE=00, BS_AMT=3 accepted at edge N -> D_OUT=8'hA0 with OUT_VALID=1 after edge N+2, for exactly 1 cycle.
- Back-to-back burst on consecutive cycles, each with D_IN=8'hB4:
  - right logical 2 -> 8'h2D
  - right arithmetic 2 -> 8'hED
  - left rotate 3 -> 8'hA5
  - right rotate 1 -> 8'h5A
  - any mode, amount 0 -> 8'hB4
  - Required: the 5 results appear on 5 consecutive cycles, in order.
- Backpressure: run the same burst with OUT_READY held 0 for 4 cycles mid-stream -> D_OUT is held, IN_READY=0 during the stall, and no result is lost or duplicated.
- Reserved mode: BS_MODE=11, right, amount 4, D_IN=8'hF0 -> 8'h0F, identical to logical.
- Randomised check: 1000 random operations with random OUT_READY and IN_VALID toggling, compared against a reference model -> zero mismatches. Repeat the run with IWIDTH=32, SWIDTH=5.

Source files
------------

// File: rtl/pipelined_barrel_shifter_if.sv
// Operand, result and valid/ready handshake bundle for the pipelined barrel shifter.
// The master side drives operations and accepts results; the slave side is the shifter.
interface pipelined_barrel_shifter_if #(
    parameter int IWIDTH = 8,
    parameter int SWIDTH = 3
);
    logic              in_valid;
    logic              in_ready;
    logic              bs_dir;
    logic [1:0]        bs_mode;
    logic [SWIDTH-1:0] bs_amt;
    logic [IWIDTH-1:0] d_in;
    logic              out_valid;
    logic              out_ready;
    logic [IWIDTH-1:0] d_out;

    modport master (
        output in_valid, bs_dir, bs_mode, bs_amt, d_in, out_ready,
        input  in_ready, out_valid, d_out
    );

    modport slave (
        input  in_valid, bs_dir, bs_mode, bs_amt, d_in, out_ready,
        output in_ready, out_valid, d_out
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: stage k conditionally shifts by 2^k. Logical, arithmetic
// and rotate modes; a single enable stalls every stage when the result is not taken.
module pipelined_barrel_shifter #(
    parameter int IWIDTH = 8,
    parameter int SWIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    pipelined_barrel_shifter_if.slave bus
);
    if (IWIDTH < 2 || (IWIDTH & (IWIDTH - 1)) != 0 || SWIDTH != $clog2(IWIDTH)) begin : g_param_check
        $error("pipelined_barrel_shifter: IWIDTH must be a power of two >= 2 and SWIDTH = log2(IWIDTH)");
    end

    typedef enum logic [1:0] {
        MODE_LOGICAL  = 2'b00,
        MODE_ARITH    = 2'b01,
        MODE_ROTATE   = 2'b10,
        MODE_RESERVED = 2'b11
    } mode_e;

    typedef struct packed {
        logic              valid;
        logic              dir;
        logic [1:0]        mode;
        logic              sign;
        logic [SWIDTH-1:0] amt;
        logic [IWIDTH-1:0] data;
    } stage_t;

    stage_t st  [SWIDTH];
    stage_t nxt [SWIDTH];
    logic   en;

    // One conditional shift by s; sign is the MSB of the original operand, not of x.
    function automatic logic [IWIDTH-1:0] shift_step(
        input logic [IWIDTH-1:0] x,
        input int unsigned       s,
        input logic              do_shift,
        input logic              dir,
        input logic [1:0]        mode,
        input logic              sign
    );
        logic [IWIDTH-1:0] fill;
        fill = ~({IWIDTH{1'b1}} >> s);
        if (!do_shift) begin
            shift_step = x;
        end else if (dir) begin
            case (mode_e'(mode))
                MODE_ARITH:  shift_step = (x >> s) | (sign ? fill : '0);
                MODE_ROTATE: shift_step = (x >> s) | (x << (IWIDTH - s));
                default:     shift_step = x >> s;
            endcase
        end else begin
            case (mode_e'(mode))
                MODE_ROTATE: shift_step = (x << s) | (x >> (IWIDTH - s));
                default:     shift_step = x << s;
            endcase
        end
    endfunction

    assign en            = !st[SWIDTH-1].valid || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = st[SWIDTH-1].valid;
    assign bus.d_out     = st[SWIDTH-1].data;

    always_comb begin
        nxt[0].valid = bus.in_valid;
        nxt[0].dir   = bus.bs_dir;
        nxt[0].mode  = bus.bs_mode;
        nxt[0].sign  = bus.d_in[IWIDTH-1];
        nxt[0].amt   = bus.bs_amt;
        nxt[0].data  = shift_step(bus.d_in, 1, bus.bs_amt[0], bus.bs_dir, bus.bs_mode,
                                  bus.d_in[IWIDTH-1]);
        for (int k = 1; k < SWIDTH; k++) begin
            // NOTE: whole stage copied first so every field has a value on every path (no latch).
            nxt[k]      = st[k-1];
            nxt[k].data = shift_step(st[k-1].data, 1 << k, st[k-1].amt[k], st[k-1].dir,
                                     st[k-1].mode, st[k-1].sign);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the stage array is cleared, not just the valid bits, so D_OUT reads zero in reset.
            for (int k = 0; k < SWIDTH; k++) st[k] <= '0;
        end else if (en) begin
            // NOTE: non-blocking so every stage samples pre-edge values and the pipe moves as one.
            for (int k = 0; k < SWIDTH; k++) st[k] <= nxt[k];
        end
    end
endmodule
